// File: rtl/tdc_result_fifo.sv
// TDC result buffer: FWFT FIFO of tagged {addr,data} reads with
// overflow counting and an almost-full hold-off toward the TDC reader.
module tdc_result_fifo #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [3:0]                addr_in,
  input  logic [27:0]               data_in,
  output logic                      read_inhibit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          ovf_cnt,
  input  logic                      clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_EMPTY  = 3'b001,
    S_ACTIVE = 3'b010,
    S_FULL   = 3'b100
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   last_q;
  logic [LW-1:0] level_nxt;
  logic          legal;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  // An illegal state freezes both pointers until it resolves to EMPTY.
  assign legal     = (state == S_ACTIVE) || (state == S_FULL)
                   || (state == S_EMPTY);
  assign out_valid = (state == S_ACTIVE) || (state == S_FULL);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign push_ok   = legal & in_valid & (~full | pop);
  assign drop      = in_valid & ~push_ok;
  assign out_data  = out_valid ? mem[rd_ptr] : last_q;

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push_ok)
      level_nxt = level - LW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:
        if (push_ok) state_nxt = S_ACTIVE;
      S_ACTIVE:
        if (level_nxt == LW'(DEPTH))
          state_nxt = S_FULL;
        else if (level_nxt == '0)
          state_nxt = S_EMPTY;
      S_FULL:
        if (level_nxt != LW'(DEPTH))
          state_nxt = S_ACTIVE;
      default:
        state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {addr_in, data_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_EMPTY;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      last_q       <= '0;
      read_inhibit <= 1'b1;
    end else begin
      state        <= state_nxt;
      level        <= level_nxt;
      read_inhibit <= (level_nxt >= LW'(AFULL_LVL));
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
    end
  end

  // A drop coinciding with a clear is counted after the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      ovf_cnt  <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (!(&ovf_cnt))
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule
